// File: rtl/sha256_ctrl_pkg.sv
// Shared control definitions for the SHA-256 compression engine.
// Holds the block-sequencing state encoding and the round geometry used by
// the round sequencer, the round datapath and the message schedule.
package sha256_ctrl_pkg;

  localparam int unsigned NUM_ROUNDS = 64;  // compression rounds per block
  localparam int unsigned IDX_WIDTH  = 6;   // round index width
  localparam int unsigned MSG_WORDS  = 16;  // rounds that take W from the message

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } sha_state_t;

endpackage

// File: rtl/sha256_round_index_counter.sv
// Round index register for the SHA-256 sequencer.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (clears count)
//   clear    : synchronous clear to 0 (wins over enable)
//   enable   : advance by one; saturates at TERMINAL
//   count    : current round index
//   terminal : count == TERMINAL
module sha256_round_index_counter
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = IDX_WIDTH,
  parameter int unsigned TERMINAL = NUM_ROUNDS - 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

  assign terminal = (count == TC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_round_sequencer.sv
// Control FSM sequencing one 512-bit SHA-256 block compression:
// IDLE -> LOAD (message handshake) -> ROUND x NUM_ROUNDS -> FINAL -> DONE.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   start       : compress one block (sampled in IDLE only)
//   msg_valid   : message block present; accepted with msg_ready
//   stall       : freeze round advance this cycle
//   abort       : synchronous cancel of the current block
//   msg_ready   : high in LOAD
//   round_index : current round number (registered)
//   round_valid : datapath executes round_index this cycle
//   first_round : round_valid on round 0
//   last_round  : round_valid on round NUM_ROUNDS-1
//   w_from_msg  : round_valid on a round that takes W from the message
//   final_add   : single FINAL cycle, add working vars into H
//   busy        : not IDLE
//   done        : one-cycle pulse in DONE
module sha256_round_sequencer
  import sha256_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = sha256_ctrl_pkg::NUM_ROUNDS,
  parameter int unsigned IDX_WIDTH  = sha256_ctrl_pkg::IDX_WIDTH,
  parameter int unsigned MSG_WORDS  = sha256_ctrl_pkg::MSG_WORDS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 msg_valid,
  input  logic                 stall,
  input  logic                 abort,
  output logic                 msg_ready,
  output logic [IDX_WIDTH-1:0] round_index,
  output logic                 round_valid,
  output logic                 first_round,
  output logic                 last_round,
  output logic                 w_from_msg,
  output logic                 final_add,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IDX_WIDTH-1:0] MSG_LIMIT = IDX_WIDTH'(MSG_WORDS);

  sha_state_t state_q, state_d;
  logic       idx_clear;
  logic       idx_enable;
  logic       idx_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)               state_d = LOAD;
      LOAD:    if (msg_valid)           state_d = ROUND;
      ROUND:   if (!stall && idx_last)  state_d = FINAL;
      FINAL:                            state_d = DONE;
      DONE:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // The index is cleared on every entry to IDLE (completion or abort), so it
  // is already 0 when LOAD hands over to the first round; during FINAL and
  // DONE it holds at the last round.
  assign idx_clear  = (state_d == IDLE);
  assign idx_enable = (state_q == ROUND) && !stall && !abort;

  sha256_round_index_counter #(
    .WIDTH    (IDX_WIDTH),
    .TERMINAL (NUM_ROUNDS - 1)
  ) u_index (
    .clock    (clock),
    .reset    (reset),
    .clear    (idx_clear),
    .enable   (idx_enable),
    .count    (round_index),
    .terminal (idx_last)
  );

  always_comb begin
    msg_ready   = (state_q == LOAD);
    round_valid = (state_q == ROUND) && !stall;
    first_round = round_valid && (round_index == '0);
    last_round  = round_valid && idx_last;
    w_from_msg  = round_valid && (round_index < MSG_LIMIT);
    final_add   = (state_q == FINAL);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
  end

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Self-checking bench for sha256_round_sequencer: directed scenarios plus
// randomized stimulus, compared each cycle against a phase/round-count model,
// with per-block latency and round-sequence scoreboarding.
module tb_sha256_round_sequencer;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_ROUND = 2;
  localparam int P_FINAL = 3;
  localparam int P_DONE  = 4;
  localparam int ROUNDS  = 64;
  localparam int MSGW    = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       msg_valid = 1'b0;
  logic       stall = 1'b0;
  logic       abort = 1'b0;
  logic       msg_ready;
  logic [5:0] round_index;
  logic       round_valid, first_round, last_round, w_from_msg;
  logic       final_add, busy, done;

  sha256_round_sequencer #(
    .NUM_ROUNDS (64),
    .IDX_WIDTH  (6),
    .MSG_WORDS  (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .msg_valid   (msg_valid),
    .stall       (stall),
    .abort       (abort),
    .msg_ready   (msg_ready),
    .round_index (round_index),
    .round_valid (round_valid),
    .first_round (first_round),
    .last_round  (last_round),
    .w_from_msg  (w_from_msg),
    .final_add   (final_add),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int m_phase = P_IDLE;
  int m_idx = 0;
  bit in_block = 0;
  int accept_cyc = 0;
  int stall_cnt = 0;
  int rq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [13:0] observed();
    return {msg_ready, round_valid, first_round, last_round, w_from_msg,
            final_add, busy, done, round_index};
  endfunction

  function automatic logic [13:0] expected(input logic sl);
    logic rv;
    rv = (m_phase == P_ROUND) && !sl;
    return {m_phase == P_LOAD, rv, rv && m_idx == 0, rv && m_idx == ROUNDS - 1,
            rv && m_idx < MSGW, m_phase == P_FINAL, m_phase != P_IDLE,
            m_phase == P_DONE, 6'(m_idx)};
  endfunction

  function automatic bit rounds_in_order();
    if (rq.size() != ROUNDS) return 0;
    foreach (rq[i]) if (rq[i] != i) return 0;
    return 1;
  endfunction

  task automatic model_update(input logic st, input logic mv, input logic sl, input logic ab);
    if (!reset) begin
      m_phase = P_IDLE; m_idx = 0; in_block = 0;
    end else if (ab && m_phase != P_IDLE) begin
      m_phase = P_IDLE; m_idx = 0; in_block = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (st) m_phase = P_LOAD;
        P_LOAD: if (mv) begin
          m_phase = P_ROUND; m_idx = 0; in_block = 1;
          accept_cyc = cyc; stall_cnt = 0; rq.delete();
        end
        P_ROUND: begin
          if (sl) stall_cnt++;
          else if (m_idx == ROUNDS - 1) m_phase = P_FINAL;
          else m_idx++;
        end
        P_FINAL: m_phase = P_DONE;
        default: begin m_phase = P_IDLE; m_idx = 0; end
      endcase
    end
  endtask

  // One clock cycle: drive in the low phase, check, then clock the model.
  task automatic step(input logic st, input logic mv, input logic sl, input logic ab);
    start = st; msg_valid = mv; stall = sl; abort = ab;
    #1;
    check("outputs", 32'(observed()), 32'(expected(sl)));
    if (round_valid === 1'b1) rq.push_back(int'(round_index));
    if (m_phase == P_DONE && in_block) begin
      check("latency", cyc - accept_cyc, 66 + stall_cnt);
      check("round_sequence", 32'(rounds_in_order()), 32'd1);
      in_block = 0;
    end
    @(posedge clock);
    model_update(st, mv, sl, ab);
    cyc++;
    @(negedge clock);
  endtask

  // Drive an accepted block until the model is back in IDLE.
  task automatic run_block(input int stall_at, input int stall_len,
                           input int abort_at, input logic hold_start);
    int sc;
    logic sl, ab;
    sc = 0;
    for (int n = 0; n < 300; n++) begin
      sl = (m_phase == P_ROUND) && (m_idx == stall_at) && (sc < stall_len);
      if (sl) sc++;
      ab = (m_phase == P_ROUND) && (m_idx == abort_at);
      step(hold_start, 1'b1, sl, ab);
      if (m_phase == P_IDLE) break;
    end
    check("block_returns_idle", m_phase, P_IDLE);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    // Reset held with start and msg_valid asserted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);           // start sampled -> LOAD

    // LOAD wait with msg_valid low, then nominal block.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    run_block(-1, 0, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Stall at round 15 for 3 cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_block(15, 3, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort at round 40.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_block(-1, 0, 40, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // start held high throughout a block.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_block(-1, 0, -1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);           // IDLE re-entered: new request
    check("restart_after_idle", m_phase, P_LOAD);
    run_block(-1, 0, -1, 1'b0);

    // Asynchronous reset at round 30, between clock edges.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 100 && !(m_phase == P_ROUND && m_idx == 30); n++)
      step(1'b0, 1'b1, 1'b0, 1'b0);
    check("reached_round_30", m_idx, 30);
    #2 reset = 1'b0;
    #1 check("async_reset_clears", 32'(observed()), 32'd0);
    m_phase = P_IDLE; m_idx = 0; in_block = 0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 5000; i++)
      step(($urandom % 4) == 0, ($urandom % 3) == 0,
           ($urandom % 5) == 0, ($urandom % 300) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sha256_round_sequencer.md
Name: sha256_round_sequencer

Overview:
Control FSM that sequences one 512-bit SHA-256 block compression. It accepts a start request and a message-valid handshake, then steps a round index through 0..63. The 6-bit round index and per-round control strobes feed the downstream round-index pipeline register and the round datapath. It closes each block with a final hash-add cycle and a done pulse.

Parameters:
NUM_ROUNDS, 64, compression rounds per block; must be <= 2**IDX_WIDTH.
IDX_WIDTH, 6, width of the round index.
MSG_WORDS, 16, rounds that take W directly from the message; later rounds use the schedule.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 = in reset.
start  input  1  request to compress one block; sampled only in IDLE.
msg_valid  input  1  message block present on the datapath.
stall  input  1  freeze round advance for this cycle.
abort  input  1  synchronous cancel of the current block.
msg_ready  output  1  high in LOAD; msg_valid&&msg_ready accepts the block.
round_index  output  IDX_WIDTH  current round number; feeds the downstream round register.
round_valid  output  1  high in ROUND when stall=0: the datapath executes round_index this cycle.
first_round  output  1  round_valid && round_index==0.
last_round  output  1  round_valid && round_index==NUM_ROUNDS-1.
w_from_msg  output  1  round_valid && round_index<MSG_WORDS.
final_add  output  1  high for the single FINAL cycle; add working vars into H.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, round_index=0, all 1-bit outputs 0. Reset asserted mid-block aborts immediately; no done pulse.
- round_index is a register. All other outputs decode from the state register and round_index; they are Moore apart from the stall gating on round_valid and its derivatives.
- IDLE: start=1 -> LOAD next cycle. Otherwise stay.
- LOAD: msg_ready=1. msg_valid=1 -> ROUND next cycle with round_index=0. Otherwise wait indefinitely.
- ROUND:
  - stall=1: hold round_index; round_valid=0.
  - stall=0: round_valid=1.
    - round_index<NUM_ROUNDS-1: increment round_index.
    - round_index==NUM_ROUNDS-1: go to FINAL; round_index holds at NUM_ROUNDS-1 (no wrap).
- FINAL: final_add=1 for exactly one cycle -> DONE. stall is ignored.
- DONE: done=1 for one cycle -> IDLE; round_index is cleared to 0 on entry to IDLE.
- abort=1 in any non-IDLE state -> IDLE next cycle, round_index=0, no final_add, no done.
- Priority: reset > abort > stall > advance.
- start while busy (including the DONE cycle) is ignored and not queued.
- Latency with no stalls: msg accept in cycle T; rounds execute T+1..T+64; final_add at T+65; done at T+66; IDLE at T+67. Each stall cycle adds exactly one cycle.
- round_index never exceeds NUM_ROUNDS-1. Arithmetic is IDX_WIDTH-bit unsigned.

Decomposition:
- Shared package sha256_ctrl_pkg holds the state encoding (IDLE, LOAD, ROUND, FINAL, DONE, 3-bit), NUM_ROUNDS, IDX_WIDTH and MSG_WORDS. The round datapath and schedule blocks import the same package.
- One sub-module is natural: sha256_round_index_counter. It is an IDX_WIDTH-bit register with clear, enable and terminal-count flag, on the same async active-low reset.
- The FSM and output decode stay in the top.

Test Plan:
- Reset: hold reset=0 with start=1 and msg_valid=1 -> all outputs 0 and round_index=0. Release reset -> start samples the next edge.
- Nominal block: start pulse, msg_valid=1 on the second cycle -> round_valid high for 64 consecutive cycles, with round_index 0..63.
  - first_round only at index 0; w_from_msg at indices 0..15; last_round only at 63.
  - final_add one cycle, then done one cycle, then busy=0.
- Stalls: assert stall at round_index=15 for 3 cycles -> index holds at 15 and round_valid=0 for those cycles. Total done latency grows by exactly 3.
- Abort: abort=1 at round_index=40 -> next cycle state IDLE, round_index=0, busy=0. No final_add or done ever appears.
- Ignored start and LOAD wait: start=1 throughout a block -> no second block starts until IDLE is re-entered. msg_valid held low 10 cycles in LOAD -> msg_ready stays 1 and round_index stays 0.
- Async reset mid-round: drive reset=0 between clock edges at round_index=30 -> outputs clear before the next edge. No done pulse follows.
